rat_alu: RTL and testbench
==========================

// Module: rat_alu
// PURPOSE
//   Parametrised multi-op rational arithmetic unit; successor to the single-op rational adder.
//   Takes two fractions (l_num/l_den, r_num/r_den) and computes their add, sub, mul or div, unreduced.
//   Uses a valid/ready handshake on both input and output. Holds one operation in flight.
//   Sits between the operand sequencer and the result writeback in the rational datapath.
// PARAMETERS
//   WIDTH  32  bit width of every numerator/denominator; all arithmetic is modulo 2^WIDTH
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand/op set presented
//   in_ready   out  1      unit can accept; high only in IDLE
//   op         in   2      0=ADD 1=SUB 2=MUL 3=DIV
//   l_num      in   WIDTH  left numerator
//   l_den      in   WIDTH  left denominator
//   r_num      in   WIDTH  right numerator
//   r_den      in   WIDTH  right denominator
//   out_valid  out  1      result valid (the rdy of the previous generation)
//   out_ready  in   1      consumer accepts result
//   s_num      out  WIDTH  result numerator
//   s_den      out  WIDTH  result denominator
//   dz         out  1      s_den==0 for the presented result
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE; out_valid=0, s_num=0, s_den=0, dz=0, in_ready=1.
//     Any in-flight op is discarded.
//   - Arithmetic: unsigned, low WIDTH bits of each product and sum are kept, no saturation.
//     ADD: num = l_num*r_den + l_den*r_num;  den = l_den*r_den
//     SUB: num = l_num*r_den - l_den*r_num;  den = l_den*r_den   (wraps mod 2^WIDTH)
//     MUL: num = l_num*r_num;                den = l_den*r_den
//     DIV: num = l_num*r_den;                den = l_den*r_num
//   - FSM states and transitions:
//     IDLE -> PROD on in_valid & in_ready; operands and op are captured on that edge.
//     PROD -> COMB: the four cross products are registered.
//     COMB -> DONE: num/den are formed and registered to s_num/s_den, dz=(den==0).
//       With RAT_POW2_REDUCE_EN defined, COMB goes to RED instead of DONE.
//     DONE: out_valid=1.
//       Stays in DONE, with s_num/s_den/dz stable, while out_ready=0.
//       DONE -> IDLE on out_ready; out_valid drops on the next edge.
//   - Latency: out_valid rises on the 3rd rising edge, counting the accepting edge as the 1st.
//   - Throughput: one op per 4 cycles minimum. No bypass from DONE to accept.
//   - in_valid while in_ready=0 is ignored. Operands are sampled only on the accepting edge.
//   - op changes after acceptance do not affect the in-flight result.
//   - rst asserted in any state: immediate return to IDLE, outputs cleared as at reset.
// CONFIGURATION
//   RAT_POW2_REDUCE_EN defined:
//     - COMB -> RED. Each RED cycle shifts s_num and s_den right by 1
//       while both are even and both are nonzero.
//     - RED -> DONE when either value is odd or either is zero; at most WIDTH-1 RED cycles.
//     - dz is evaluated on the final s_den.
//   RAT_POW2_REDUCE_EN undefined:
//     - No RED state and no reduction; latency is fixed at 3 edges.
// STRUCTURE
//   - Package rat_pkg: rat_op_t enum (ADD, SUB, MUL, DIV) and rat_state_t enum (IDLE, PROD, COMB, RED, DONE).
//   - Sub-module rat_pow2_reduce: the shift loop, with start/done handshake.
//     Instantiated only under RAT_POW2_REDUCE_EN.
// TESTING (WIDTH=32)
//   1. ADD 1/2 + 1/3 -> s=5/6, dz=0; out_valid on 3rd edge from accept; in_ready=0 until DONE exits.
//   2. SUB 1/3 - 1/2 -> s_num=32'hFFFF_FFFF, s_den=6 (modular wrap).
//   3. DIV 3/4 / 0/5 -> s_num=15, s_den=0, dz=1.
//   4. MUL 2/4 * 6/8 -> 12/32 without macro; with RAT_POW2_REDUCE_EN -> 3/8 after 2 RED cycles.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid and operands
//      -> s_num/s_den/dz stable, in_ready=0, no new op accepted.
//   6. Assert rst during PROD -> out_valid=0, s_num=s_den=0 at once; in_ready=1;
//      the next op completes correctly.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types for the rational arithmetic unit: operation codes and FSM states.
package rat_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } rat_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PROD = 3'd1,
        COMB = 3'd2,
        RED  = 3'd3,
        DONE = 3'd4
    } rat_state_t;

endpackage

// File: rtl/rat_pow2_reduce.sv
// Strips common factors of two from a num/den pair, one shift per cycle.
// done is asserted in the cycle whose outputs can no longer be reduced.
module rat_pow2_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] den_in,
    output logic             done,
    output logic [WIDTH-1:0] num_out,
    output logic [WIDTH-1:0] den_out
);

    logic [WIDTH-1:0] num_q, den_q;
    logic             active;
    logic             can_shift, can_shift_nxt;

    assign can_shift     = (num_q != '0) && (den_q != '0) && !num_q[0] && !den_q[0];
    assign num_out       = can_shift ? (num_q >> 1) : num_q;
    assign den_out       = can_shift ? (den_q >> 1) : den_q;
    // Look one shift ahead so the pair leaves on the cycle that produces the final value.
    assign can_shift_nxt = (num_out != '0) && (den_out != '0) && !num_out[0] && !den_out[0];
    assign done          = active && !can_shift_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= '0;
            den_q  <= '0;
            active <= 1'b0;
        end else if (start) begin
            num_q  <= num_in;
            den_q  <= den_in;
            active <= 1'b1;
        end else if (active) begin
            num_q <= num_out;
            den_q <= den_out;
            if (!can_shift_nxt)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/rat_alu.sv
// Multi-op rational arithmetic unit (add/sub/mul/div, unreduced, modulo 2^WIDTH).
// Optional power-of-two reduction stage enabled by defining RAT_POW2_REDUCE_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// PROD  | four cross products being registered
// COMB  | num/den formed from the products
// RED   | shifting out common factors of two (RAT_POW2_REDUCE_EN only)
// DONE  | result presented, waiting for out_ready
module rat_alu
    import rat_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             dz
);

    rat_state_t       state, state_nxt;
    rat_op_t          op_q;
    logic [WIDTH-1:0] l_num_q, l_den_q, r_num_q, r_den_q;
    logic [WIDTH-1:0] p_lnrd, p_ldrn, p_lnrn, p_ldrd;
    logic [WIDTH-1:0] num_c, den_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef RAT_POW2_REDUCE_EN
    logic             red_done;
    logic [WIDTH-1:0] red_num, red_den;

    rat_pow2_reduce #(.WIDTH(WIDTH)) u_reduce (
        .clk     (clk),
        .rst     (rst),
        .start   (state == COMB),
        .num_in  (num_c),
        .den_in  (den_c),
        .done    (red_done),
        .num_out (red_num),
        .den_out (red_den)
    );
`endif

    always_comb begin
        num_c = p_lnrd;
        den_c = p_ldrd;
        case (op_q)
            ADD: num_c = p_lnrd + p_ldrn;
            SUB: num_c = p_lnrd - p_ldrn;
            MUL: num_c = p_lnrn;
            DIV: begin
                num_c = p_lnrd;
                den_c = p_ldrn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = PROD;
            PROD: state_nxt = COMB;
`ifdef RAT_POW2_REDUCE_EN
            COMB: state_nxt = RED;
            RED:  if (red_done) state_nxt = DONE;
`else
            COMB: state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= ADD;
            l_num_q <= '0;
            l_den_q <= '0;
            r_num_q <= '0;
            r_den_q <= '0;
            p_lnrd  <= '0;
            p_ldrn  <= '0;
            p_lnrn  <= '0;
            p_ldrd  <= '0;
            s_num   <= '0;
            s_den   <= '0;
            dz      <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                op_q    <= rat_op_t'(op);
                l_num_q <= l_num;
                l_den_q <= l_den;
                r_num_q <= r_num;
                r_den_q <= r_den;
            end
            if (state == PROD) begin
                p_lnrd <= l_num_q * r_den_q;
                p_ldrn <= l_den_q * r_num_q;
                p_lnrn <= l_num_q * r_num_q;
                p_ldrd <= l_den_q * r_den_q;
            end
            if (state == COMB) begin
                s_num <= num_c;
                s_den <= den_c;
                dz    <= (den_c == '0);
            end
`ifdef RAT_POW2_REDUCE_EN
            if (state == RED && red_done) begin
                s_num <= red_num;
                s_den <= red_den;
                dz    <= (red_den == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_rat_alu.sv
// Self-checking bench for rat_alu: vector table driven through a scoreboard,
// plus backpressure and reset-during-operation sequences.
module tb_rat_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] l_num, l_den, r_num, r_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_num, s_den;
    logic         dz;

    rat_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .l_num     (l_num),
        .l_den     (l_den),
        .r_num     (r_num),
        .r_den     (r_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_num     (s_num),
        .s_den     (s_den),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] ln, ld, rn, rd;
        logic [W-1:0] en, ed;
        int           hold;
    } vec_t;

    typedef struct {
        logic [W-1:0] n, d;
        logic         z;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        int   shifts;
        shifts = 0;
        e.n = n;
        e.d = d;
`ifdef RAT_POW2_REDUCE_EN
        while (e.n != 0 && e.d != 0 && !e.n[0] && !e.d[0]) begin
            e.n = e.n >> 1;
            e.d = e.d >> 1;
            shifts++;
        end
        e.lat = 3 + ((shifts == 0) ? 1 : shifts);
`else
        e.lat = 3;
`endif
        e.z = (e.d == 0);
        return e;
    endfunction

    function automatic vec_t ref_vec(input logic [1:0] o, input logic [W-1:0] ln, input logic [W-1:0] ld,
                                     input logic [W-1:0] rn, input logic [W-1:0] rd);
        vec_t v;
        v.op = o; v.ln = ln; v.ld = ld; v.rn = rn; v.rd = rd; v.hold = 1;
        v.ed = ld * rd;
        case (o)
            2'd0: v.en = ln * rd + ld * rn;
            2'd1: v.en = ln * rd - ld * rn;
            2'd2: v.en = ln * rn;
            default: begin
                v.en = ln * rd;
                v.ed = ld * rn;
            end
        endcase
        return v;
    endfunction

    task automatic scramble_inputs();
        op    = 2'($urandom);
        l_num = $urandom;
        l_den = $urandom;
        r_num = $urandom;
        r_den = $urandom;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int   edges;
        @(negedge clk);
        check({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1; out_ready = 1'b0;
        op = v.op; l_num = v.ln; l_den = v.ld; r_num = v.rn; r_den = v.rd;
        @(posedge clk);
        sb.push_back(make_exp(v.en, v.ed));
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        edges = 1;
        while (!out_valid && edges < 40) begin
            check({tag, " in_ready busy"}, in_ready, 0);
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) begin
            check({tag, " out_valid timeout"}, 0, 1);
            void'(sb.pop_front());
            return;
        end
        check({tag, " latency"}, edges, sb[0].lat);
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            in_valid = k[0] ? 1'b0 : 1'b1;
            scramble_inputs();
            @(posedge clk);
            #1;
            check({tag, " hold s_num"}, s_num, sb[0].n);
            check({tag, " hold s_den"}, s_den, sb[0].d);
            check({tag, " hold dz"}, dz, sb[0].z);
            check({tag, " hold out_valid"}, out_valid, 1);
            check({tag, " hold in_ready"}, in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        check({tag, " s_num"}, s_num, e.n);
        check({tag, " s_den"}, s_den, e.d);
        check({tag, " dz"}, dz, e.z);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " out_valid drop"}, out_valid, 0);
        check({tag, " in_ready back"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vec_t rv;
        vecs[0] = '{2'd0, 32'd1, 32'd2, 32'd1, 32'd3, 32'd5, 32'd6, 0};
        vecs[1] = '{2'd1, 32'd1, 32'd3, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'd6, 1};
        vecs[2] = '{2'd3, 32'd3, 32'd4, 32'd0, 32'd5, 32'd15, 32'd0, 1};
        vecs[3] = '{2'd2, 32'd2, 32'd4, 32'd6, 32'd8, 32'd12, 32'd32, 5};
        vecs[4] = '{2'd0, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1, 32'd0, 32'd1, 0};
        vecs[5] = '{2'd2, 32'h0001_0000, 32'd3, 32'h0001_0000, 32'd5, 32'd0, 32'd15, 0};
        vecs[6] = '{2'd3, 32'd7, 32'd9, 32'd2, 32'd3, 32'd21, 32'd18, 2};
        vecs[7] = '{2'd1, 32'd5, 32'd1, 32'd2, 32'd1, 32'd3, 32'd1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; l_num = '0; l_den = '0; r_num = '0; r_den = '0;
        #12;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset s_num", s_num, 0);
        check("reset s_den", s_den, 0);
        check("reset dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            rv = ref_vec(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
            run_op(rv, $sformatf("rand%0d", i));
        end

        // Reset while the op is in PROD; the previous result is still on s_num/s_den.
        @(negedge clk);
        in_valid = 1'b1;
        op = 2'd0; l_num = 32'd9; l_den = 32'd2; r_num = 32'd1; r_den = 32'd4;
        @(posedge clk);
        sb.push_back(make_exp(32'd38, 32'd8));
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst s_num", s_num, 0);
        check("rst s_den", s_den, 0);
        check("rst dz", dz, 0);
        check("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run_op(vecs[6], "post_rst");

        check("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
